// File: rtl/eeg_oram_pkg.sv
// Shared types and default widths for the ORAM bank controllers.
package eeg_oram_pkg;

    localparam int ORAM_ADD_AW = 12;
    localparam int OMUX_ADD_AW = 10;
    localparam int ORAM_DAT_DW = 4;

    typedef struct packed {
        logic                   lst;
        logic [ORAM_DAT_DW-1:0] dat;
    } oram_rd_ent_t;

    typedef enum logic {
        PREF_WR = 1'b0,
        PREF_RD = 1'b1
    } pref_t;

endpackage

// File: rtl/eeg_oram_bank_ctrl_if.sv
// Bank-side channels: write requests and read addresses in, read data and write-done out.
interface eeg_oram_bank_ctrl_if import eeg_oram_pkg::*; #(
    parameter int ADD_AW = OMUX_ADD_AW,
    parameter int DAT_DW = ORAM_DAT_DW
);
    logic              mtoo_dat_vld;
    logic              mtoo_dat_lst;
    logic              mtoo_dat_rdy;
    logic [ADD_AW-1:0] mtoo_dat_add;
    logic [DAT_DW-1:0] mtoo_dat_dat;

    logic              mtoo_add_vld;
    logic              mtoo_add_lst;
    logic              mtoo_add_rdy;
    logic [ADD_AW-1:0] mtoo_add_add;

    logic              otom_dat_vld;
    logic              otom_dat_lst;
    logic              otom_dat_rdy;
    logic [DAT_DW-1:0] otom_dat_dat;

    logic              wr_done;

    modport master (
        output mtoo_dat_vld, mtoo_dat_lst, mtoo_dat_add, mtoo_dat_dat,
        input  mtoo_dat_rdy,
        output mtoo_add_vld, mtoo_add_lst, mtoo_add_add,
        input  mtoo_add_rdy,
        input  otom_dat_vld, otom_dat_lst, otom_dat_dat,
        output otom_dat_rdy,
        input  wr_done
    );

    modport slave (
        input  mtoo_dat_vld, mtoo_dat_lst, mtoo_dat_add, mtoo_dat_dat,
        output mtoo_dat_rdy,
        input  mtoo_add_vld, mtoo_add_lst, mtoo_add_add,
        output mtoo_add_rdy,
        output otom_dat_vld, otom_dat_lst, otom_dat_dat,
        input  otom_dat_rdy,
        output wr_done
    );
endinterface

// File: rtl/eeg_sync_fifo.sv
// Flop-based synchronous FIFO with occupancy count; head entry drives pop_dat directly.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the owner must never push when full (push+pop same cycle is legal).
module eeg_sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
    assign empty   = (count == '0);
endmodule

// File: rtl/eeg_oram_bank_ctrl.sv
// Per-bank SRAM controller: round-robin between writes and reads, reads return in order via a FIFO.
// Latency: write 1 cycle to SRAM; read data appears 2 cycles after read acceptance when the FIFO is empty.
// Backpressure: reads are credit-limited by FIFO space + in-flight read, so OTOM stalls never drop data.
module eeg_oram_bank_ctrl import eeg_oram_pkg::*; #(
    parameter int ADD_AW     = OMUX_ADD_AW,
    parameter int DAT_DW     = ORAM_DAT_DW,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    eeg_oram_bank_ctrl_if.slave  bus,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADD_AW-1:0]    ram_add,
    output logic [DAT_DW-1:0]    ram_wdat,
    input  logic [DAT_DW-1:0]    ram_rdat
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    pref_t         pref_q;
    pref_t         pref_d;
    logic          inflight;
    logic          inflight_lst;
    logic [CW-1:0] count;
    logic [CW:0]   crd_sum;
    logic          crd_ok;
    logic          wr_fire;
    logic          rd_fire;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [DAT_DW:0] fifo_head;

    // The read being fetched this cycle already owns a FIFO slot.
    assign crd_sum = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign crd_ok  = crd_sum < (CW+1)'(FIFO_DEPTH);

    // Ready never looks at its own valid; rst_n gating keeps the SRAM quiet during reset.
    assign bus.mtoo_dat_rdy = rst_n && !(bus.mtoo_add_vld && crd_ok && (pref_q == PREF_RD));
    assign bus.mtoo_add_rdy = rst_n && crd_ok && !(bus.mtoo_dat_vld && (pref_q == PREF_WR));

    assign wr_fire = bus.mtoo_dat_vld && bus.mtoo_dat_rdy;
    assign rd_fire = bus.mtoo_add_vld && bus.mtoo_add_rdy;

    always_comb begin
        pref_d = pref_q;
        if (bus.mtoo_dat_vld && bus.mtoo_add_vld && crd_ok) begin
            pref_d = wr_fire ? PREF_RD : PREF_WR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pref_q       <= PREF_WR;
            inflight     <= 1'b0;
            inflight_lst <= 1'b0;
            bus.wr_done  <= 1'b0;
        end else begin
            pref_q      <= pref_d;
            inflight    <= rd_fire;
            bus.wr_done <= wr_fire && bus.mtoo_dat_lst;
            if (rd_fire) inflight_lst <= bus.mtoo_add_lst;
        end
    end

    assign ram_en   = wr_fire || rd_fire;
    assign ram_we   = wr_fire;
    assign ram_add  = rd_fire ? bus.mtoo_add_add : bus.mtoo_dat_add;
    assign ram_wdat = bus.mtoo_dat_dat;

    assign fifo_pop = bus.otom_dat_vld && bus.otom_dat_rdy;

    eeg_sync_fifo #(
        .WIDTH (DAT_DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight),
        .push_dat ({inflight_lst, ram_rdat}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .count    (count),
        .empty    (fifo_empty)
    );

    assign bus.otom_dat_vld = !fifo_empty;
    assign bus.otom_dat_lst = fifo_head[DAT_DW];
    assign bus.otom_dat_dat = fifo_head[DAT_DW-1:0];
endmodule
